// File: rtl/turf_cmd_rx.sv
// TURF serial command receiver: synchronizes CMD, deframes start/evt/buf/parity/stop
// frames and presents decoded digitize requests on a valid/ack handshake.
module turf_cmd_rx #(
    parameter int unsigned EVT_BITS    = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                CMD,
    output logic                cmd_valid_o,
    input  logic                cmd_ack_i,
    output logic [1:0]          cmd_buf_o,
    output logic [EVT_BITS-1:0] cmd_evt_o,
    output logic                err_o,
    output logic [7:0]          err_cnt_o,
    output logic                overflow_o,
    input  logic                clr_err_i
);

    localparam int unsigned SR_W  = EVT_BITS + 3;
    localparam int unsigned CNT_W = $clog2(EVT_BITS + 3);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(EVT_BITS + 2);

    typedef enum logic [1:0] {StIdle, StShift, StStop} state_e;

    state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic                valid_q, valid_d;
    logic [1:0]          buf_q, buf_d;
    logic [EVT_BITS-1:0] evt_q, evt_d;
    logic                err_q, err_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                ovf_q, ovf_d;

    logic cmd_s;
    logic parity_ok, frame_good, frame_bad, load, drop, err_event;

    assign cmd_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            sync_q    <= '0;
            cnt_q     <= '0;
            sr_q      <= '0;
            valid_q   <= 1'b0;
            buf_q     <= '0;
            evt_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], CMD};
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            valid_q   <= valid_d;
            buf_q     <= buf_d;
            evt_q     <= evt_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    // Shift register holds {evt, buf, parity}; even parity means the XOR of all of it is 0.
    assign parity_ok  = ~^sr_q;
    assign frame_good = (state_q == StStop) && !cmd_s && parity_ok;
    assign frame_bad  = (state_q == StStop) && (cmd_s || !parity_ok);
    assign load       = frame_good && (!valid_q || cmd_ack_i);
    assign drop       = frame_good && valid_q && !cmd_ack_i;
    assign err_event  = frame_bad || drop;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_s) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                sr_d  = {sr_q[SR_W-2:0], cmd_s};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = StStop;
                end
            end
            StStop:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        valid_d   = valid_q;
        buf_d     = buf_q;
        evt_d     = evt_q;
        err_d     = err_event;
        err_cnt_d = err_cnt_q;
        ovf_d     = ovf_q;
        // A new load takes priority over a same-cycle ack.
        if (load) begin
            valid_d = 1'b1;
            buf_d   = sr_q[2:1];
            evt_d   = sr_q[SR_W-1 -: EVT_BITS];
        end else if (cmd_ack_i) begin
            valid_d = 1'b0;
        end
        if (clr_err_i) begin
            err_cnt_d = '0;
            ovf_d     = 1'b0;
        end else begin
            if (err_event && err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    assign cmd_valid_o = valid_q;
    assign cmd_buf_o   = buf_q;
    assign cmd_evt_o   = evt_q;
    assign err_o       = err_q;
    assign err_cnt_o   = err_cnt_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_turf_cmd_rx.sv
// Directed and randomized checks of turf_cmd_rx against a frame-level reference model.
module tb_turf_cmd_rx;

    localparam int unsigned EVT_BITS = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd = 1'b0;
    logic          ack = 1'b0;
    logic          clr = 1'b0;
    logic          valid;
    logic [1:0]    bufn;
    logic [11:0]   evt;
    logic          err;
    logic [7:0]    err_cnt;
    logic          ovf;

    int n_assert = 0;
    int n_fail   = 0;
    int err_seen = 0;

    turf_cmd_rx #(.EVT_BITS(EVT_BITS), .SYNC_STAGES(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .CMD         (cmd),
        .cmd_valid_o (valid),
        .cmd_ack_i   (ack),
        .cmd_buf_o   (bufn),
        .cmd_evt_o   (evt),
        .err_o       (err),
        .err_cnt_o   (err_cnt),
        .overflow_o  (ovf),
        .clr_err_i   (clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (err === 1'b1) err_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 cmd = 1'b0;
        end
    endtask

    // Drives the first nbits of a frame, one bit per cycle, MSB first.
    task automatic send_frame(input logic [11:0] e, input logic [1:0] b, input bit bad_par,
                              input bit stop, input int nbits);
        logic       p;
        logic [16:0] f;
        p = (^{e, b}) ^ bad_par;
        f = {1'b1, e, b, p, stop};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk);
            #1 cmd = f[16-i];
        end
    endtask

    // Frame-level reference model state.
    bit         m_valid;
    logic [11:0] m_evt;
    logic [1:0] m_buf;
    int         m_cnt;
    bit         m_ovf;

    initial begin
        int snap;
        // Reset values
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_evt", evt, 0);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;

        // Good frame latency and ack
        send_frame(12'hABC, 2'd2, 0, 0, 17);
        idle(2);
        chk("lat_early", valid, 0);
        idle(1);
        chk("lat_valid", valid, 1);
        chk("lat_evt", evt, 12'hABC);
        chk("lat_buf", bufn, 2);
        chk("lat_err", err, 0);
        ack = 1'b1;
        idle(1);
        ack = 1'b0;
        chk("ack_clear", valid, 0);
        ack = 1'b1;
        idle(1);
        ack = 1'b0;
        chk("ack_ignored", valid, 0);

        // Parity error then stop-bit error
        snap = err_seen;
        send_frame(12'hABC, 2'd2, 1, 0, 17);
        idle(3);
        chk("par_err", err, 1);
        chk("par_valid", valid, 0);
        chk("par_cnt", err_cnt, 1);
        send_frame(12'hABC, 2'd2, 0, 1, 17);
        idle(3);
        chk("stop_cnt", err_cnt, 2);
        chk("stop_valid", valid, 0);
        idle(1);
        chk("err_pulses", err_seen - snap, 2);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("clr_cnt", err_cnt, 0);

        // Back-to-back good frames with no ack: second dropped
        send_frame(12'h001, 2'd0, 0, 0, 17);
        send_frame(12'h002, 2'd1, 0, 0, 17);
        idle(3);
        chk("b2b_valid", valid, 1);
        chk("b2b_evt", evt, 12'h001);
        chk("b2b_buf", bufn, 0);
        chk("b2b_ovf", ovf, 1);
        chk("b2b_cnt", err_cnt, 1);
        chk("b2b_err", err, 1);

        // Ack in the STOP cycle of a new good frame: load wins
        ack = 1'b1;
        idle(1);
        ack = 1'b0;
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("pre_ovf", ovf, 0);
        send_frame(12'h010, 2'd0, 0, 0, 17);
        idle(3);
        chk("pend_evt", evt, 12'h010);
        send_frame(12'h020, 2'd1, 0, 0, 17);
        idle(2);
        ack = 1'b1;
        idle(1);
        ack = 1'b0;
        chk("same_valid", valid, 1);
        chk("same_evt", evt, 12'h020);
        chk("same_buf", bufn, 1);
        chk("same_ovf", ovf, 0);
        chk("same_cnt", err_cnt, 0);

        // Saturation
        snap = err_seen;
        for (int i = 0; i < 260; i++) send_frame(12'(i), 2'(i), 1, 0, 17);
        idle(4);
        chk("sat_cnt", err_cnt, 255);
        chk("sat_pulses", err_seen - snap, 260);
        chk("sat_evt", evt, 12'h020);
        send_frame(12'h333, 2'd0, 0, 0, 17);
        idle(3);
        chk("sat_ovf", ovf, 1);
        chk("sat_ovf_cnt", err_cnt, 255);
        chk("sat_hold_evt", evt, 12'h020);
        send_frame(12'h444, 2'd2, 1, 0, 17);
        idle(2);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk("clrwin_cnt", err_cnt, 0);
        chk("clrwin_ovf", ovf, 0);
        chk("clrwin_err", err, 1);

        // Asynchronous reset mid-frame
        send_frame(12'h7FF, 2'd1, 0, 0, 8);
        #3 rst = 1'b1;
        cmd = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_evt", evt, 0);
        chk("arst_cnt", err_cnt, 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        snap = err_seen;
        idle(25);
        chk("arst_nospur", valid, 0);
        chk("arst_noerr", err_seen - snap, 0);
        send_frame(12'h5A5, 2'd3, 0, 0, 17);
        idle(2);
        chk("post_early", valid, 0);
        idle(1);
        chk("post_valid", valid, 1);
        chk("post_evt", evt, 12'h5A5);
        chk("post_buf", bufn, 3);

        // Randomized frames against the reference model
        m_valid = 1;
        m_evt   = 12'h5A5;
        m_buf   = 2'd3;
        m_cnt   = 0;
        m_ovf   = 0;
        for (int it = 0; it < 60; it++) begin
            logic [11:0] e;
            logic [1:0]  b;
            bit bp, bs, a, c, good, e_ev;
            e  = 12'($urandom);
            b  = 2'($urandom);
            bp = ($urandom % 4) == 0;
            bs = ($urandom % 6) == 0;
            a  = ($urandom % 2) == 1;
            c  = ($urandom % 8) == 0;
            send_frame(e, b, bp, bs, 17);
            idle(2);
            ack = a;
            clr = c;
            idle(1);
            ack = 1'b0;
            clr = 1'b0;
            good = !bp && !bs;
            e_ev = !good || (m_valid && !a);
            if (good && m_valid && !a && !c) m_ovf = 1;
            if (good && (!m_valid || a)) begin
                m_valid = 1;
                m_evt   = e;
                m_buf   = b;
            end else if (a) begin
                m_valid = 0;
            end
            if (c) begin
                m_cnt = 0;
                m_ovf = 0;
            end else if (e_ev && m_cnt < 255) begin
                m_cnt++;
            end
            chk("rnd_valid", valid, m_valid);
            if (m_valid) begin
                chk("rnd_evt", evt, m_evt);
                chk("rnd_buf", bufn, m_buf);
            end
            chk("rnd_cnt", err_cnt, m_cnt);
            chk("rnd_ovf", ovf, m_ovf);
            chk("rnd_err", err, e_ev);
            idle($urandom % 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
